// File: rtl/dl_reset_pkg.sv
// Shared types and constants for the download-gated reset sequencer.
// Holds the FSM state encoding and the counter/index widths.
package dl_reset_pkg;

    localparam int CNT_W = 8;
    localparam int IDX_W = 8;

    typedef enum logic [1:0] {
        S_PLL  = 2'd0,
        S_LOAD = 2'd1,
        S_HOLD = 2'd2,
        S_RUN  = 2'd3
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/dl_sync.sv
// Multi-flop synchroniser for an asynchronous level, depth SYNC_STAGES.
// Output is the oldest stage; all stages clear on reset.
module dl_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_sys,
    input  logic res_n,
    input  logic async_i,
    output logic sync_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk_sys or negedge res_n) begin
        if (!res_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= (sync_q << 1) | SYNC_STAGES'(async_i);
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/dl_reset_seq.sv
// Core reset sequencer: waits for PLL lock and required image downloads, then stretches reset.
// Optional macro DL_HOLD_EN: a required-image download starting in S_RUN drops back to S_LOAD.
//
// state  | meaning
// S_PLL  | waiting for synchronised PLL lock
// S_LOAD | waiting for all REQ_MASK images and no download in progress
// S_HOLD | stretching reset for HOLD_CYC clocks after the last request
// S_RUN  | core out of reset
module dl_reset_seq
    import dl_reset_pkg::*;
#(
    parameter int               N_SRC       = 3,
    parameter int               N_IMG       = 3,
    parameter logic [N_IMG-1:0] REQ_MASK    = 'b001,
    parameter int               HOLD_CYC    = 16,
    parameter int               SYNC_STAGES = 2
) (
    input  logic               clk_sys,
    input  logic               res_n,
    input  logic               pll_locked,
    input  logic [N_SRC-1:0]   rst_req,
    input  logic [N_IMG-1:0]   unl_req,
    input  logic               ioctl_download,
    input  logic [IDX_W-1:0]   ioctl_index,
    output logic               core_reset,
    output logic [N_IMG-1:0]   img_loaded,
    output logic [1:0]         state,
    output logic [CNT_W-1:0]   reset_cnt
);

    localparam logic [CNT_W-1:0] HOLD_RELOAD = CNT_W'(HOLD_CYC - 1);

    logic             lock_s;
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             core_reset_q;
    logic [CNT_W-1:0] reset_cnt_q;
    logic [N_IMG-1:0] img_loaded_q;
    logic [N_IMG-1:0] img_loaded_d;
    logic [N_IMG-1:0] set_vec;
    logic [N_IMG-1:0] rise_clr;
    logic             dl_prev_q;
    logic             dl_armed_q;
    logic [IDX_W-1:0] dl_idx_q;
    logic             dl_rise;
    logic             dl_fall;
    logic             req_ok;
    logic             req_lost;

    dl_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_lock_sync (
        .clk_sys(clk_sys),
        .res_n  (res_n),
        .async_i(pll_locked),
        .sync_o (lock_s)
    );

    assign dl_rise = ioctl_download & ~dl_prev_q;
    assign dl_fall = ~ioctl_download & dl_prev_q;

    // dl_prev_q resets high so a download already running at reset release
    // never looks like a fresh rising edge; only armed downloads may set a flag.
    always_ff @(posedge clk_sys or negedge res_n) begin
        if (!res_n) begin
            dl_prev_q  <= 1'b1;
            dl_armed_q <= 1'b0;
            dl_idx_q   <= '0;
        end else begin
            dl_prev_q <= ioctl_download;
            if (dl_rise) begin
                dl_idx_q   <= ioctl_index;
                dl_armed_q <= 1'b1;
            end else if (dl_fall) begin
                dl_armed_q <= 1'b0;
            end
        end
    end

    always_comb begin
        set_vec = '0;
        for (int i = 0; i < N_IMG; i++) begin
            if (dl_fall && dl_armed_q && (dl_idx_q == IDX_W'(i))) begin
                set_vec[i] = 1'b1;
            end
        end
    end

    always_comb begin
        rise_clr = '0;
`ifdef DL_HOLD_EN
        for (int i = 0; i < N_IMG; i++) begin
            if ((state_q == S_RUN) && dl_rise && REQ_MASK[i] &&
                (ioctl_index == IDX_W'(i))) begin
                rise_clr[i] = 1'b1;
            end
        end
`endif
    end

    // Clears win over a coincident set.
    assign img_loaded_d = (img_loaded_q | set_vec) & ~unl_req & ~rise_clr;

    always_ff @(posedge clk_sys or negedge res_n) begin
        if (!res_n) begin
            img_loaded_q <= '0;
        end else begin
            img_loaded_q <= img_loaded_d;
        end
    end

    assign req_ok   = ((img_loaded_q & REQ_MASK) == REQ_MASK);
    assign req_lost = ((img_loaded_d & REQ_MASK) != REQ_MASK);

    always_ff @(posedge clk_sys or negedge res_n) begin
        if (!res_n) begin
            state_q      <= S_PLL;
            cnt_q        <= '0;
            core_reset_q <= 1'b1;
            reset_cnt_q  <= '0;
        end else begin
            core_reset_q <= (state_q != S_RUN);
            if (!lock_s) begin
                state_q <= S_PLL;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    S_PLL: begin
                        state_q <= S_LOAD;
                    end
                    S_LOAD: begin
                        if (req_ok && !ioctl_download) begin
                            state_q <= S_HOLD;
                            cnt_q   <= HOLD_RELOAD;
                        end
                    end
                    S_HOLD: begin
                        if (|rst_req) begin
                            cnt_q <= HOLD_RELOAD;
                        end else if (cnt_q == '0) begin
                            state_q <= S_RUN;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    S_RUN: begin
                        // A lost required image outranks a plain reset request.
                        if (req_lost) begin
                            state_q <= S_LOAD;
                        end else if (|rst_req) begin
                            state_q     <= S_HOLD;
                            cnt_q       <= HOLD_RELOAD;
                            reset_cnt_q <= sat_inc(reset_cnt_q);
                        end
                    end
                    default: begin
                        state_q <= S_PLL;
                    end
                endcase
            end
        end
    end

    assign core_reset = core_reset_q;
    assign img_loaded = img_loaded_q;
    assign state      = state_q;
    assign reset_cnt  = reset_cnt_q;

endmodule

// File: tb/tb_dl_reset_seq.sv
// Directed bench for dl_reset_seq: expectations queued as stimulus is driven, compared on sampling.
// Build with DL_HOLD_EN defined to exercise the download-hold path.
module tb_dl_reset_seq;

    localparam int HOLD = 16;
    localparam int SYNC = 2;

    logic       clk_sys = 1'b0;
    logic       res_n;
    logic       pll_locked;
    logic [2:0] rst_req;
    logic [2:0] unl_req;
    logic       ioctl_download;
    logic [7:0] ioctl_index;
    logic       core_reset;
    logic [2:0] img_loaded;
    logic [1:0] state;
    logic [7:0] reset_cnt;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cr_hi_cnt = 0;

    dl_reset_seq #(
        .N_SRC      (3),
        .N_IMG      (3),
        .REQ_MASK   (3'b001),
        .HOLD_CYC   (HOLD),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk_sys       (clk_sys),
        .res_n         (res_n),
        .pll_locked    (pll_locked),
        .rst_req       (rst_req),
        .unl_req       (unl_req),
        .ioctl_download(ioctl_download),
        .ioctl_index   (ioctl_index),
        .core_reset    (core_reset),
        .img_loaded    (img_loaded),
        .state         (state),
        .reset_cnt     (reset_cnt)
    );

    always #5 clk_sys = ~clk_sys;

    always @(negedge clk_sys) if (core_reset) cr_hi_cnt++;

    task automatic push_exp(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        if (sb_q.size() == 0) begin
            e.tag = "scoreboard_empty";
            e.val = ~obs;
        end else begin
            e = sb_q.pop_front();
        end
        checks++;
        assert (obs === e.val) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
        end
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget, input string tag);
        int n;
        n = 0;
        while (state !== s && n < budget) begin
            @(negedge clk_sys);
            n++;
        end
        push_exp(tag, 32'(s));
        check(32'(state));
    endtask

    task automatic do_download(input logic [7:0] idx, input int len);
        ioctl_download = 1'b1;
        ioctl_index    = idx;
        repeat (len) @(negedge clk_sys);
        ioctl_download = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          hold_n;
        int          first_low;
        int          first_zero;
        int          cr_snap;
        int          timeouts;
        logic [31:0] code;
        logic [1:0]  last;

        res_n          = 1'b0;
        pll_locked     = 1'b0;
        rst_req        = '0;
        unl_req        = '0;
        ioctl_download = 1'b0;
        ioctl_index    = '0;

        // Reset values
        push_exp("rst_state", 0);
        push_exp("rst_core_reset", 1);
        push_exp("rst_img_loaded", 0);
        push_exp("rst_reset_cnt", 0);
        repeat (2) @(negedge clk_sys);
        check(32'(state));
        check(32'(core_reset));
        check(32'(img_loaded));
        check(32'(reset_cnt));

        // Lock: S_PLL -> S_LOAD, no required image so stays there
        res_n      = 1'b1;
        pll_locked = 1'b1;
        wait_state(2'd1, 10, "lock_to_load");
        push_exp("load_stays", 1);
        push_exp("load_core_reset", 1);
        repeat (3) @(negedge clk_sys);
        check(32'(state));
        check(32'(core_reset));

        // Power-up download of index 0: flag set one clock after the falling
        // edge, S_HOLD the clock after, HOLD clocks in S_HOLD, then S_RUN and
        // core_reset low one clock later => first low sample HOLD+3 after drop.
        push_exp("pu_img_loaded", 3'b001);
        push_exp("pu_hold_cycles", HOLD);
        push_exp("pu_core_reset_fall", HOLD + 3);
        push_exp("pu_state_seq", 6'b01_10_11);
        do_download(8'd0, 3);
        hold_n    = 0;
        first_low = 0;
        code      = 32'(state);
        last      = state;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk_sys);
            if (state == 2'd2) hold_n++;
            if (state != last) begin
                code = (code << 2) | 32'(state);
                last = state;
            end
            if (!core_reset && first_low == 0) first_low = n;
        end
        check(32'(img_loaded));
        check(32'(hold_n));
        check(32'(first_low));
        check(code);

        // Stretched reset: rst_req[1] for 5 clocks. 1 clock in S_RUN, 4 more
        // reloading in S_HOLD, then HOLD clocks of countdown.
        push_exp("str_cr_lag", 0);
        push_exp("str_cr_high", 1);
        push_exp("str_hold_cycles", HOLD + 4);
        push_exp("str_core_reset_fall", HOLD + 6);
        push_exp("str_reset_cnt", 1);
        rst_req   = 3'b010;
        hold_n    = 0;
        first_low = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk_sys);
            if (i == 1) check(32'(core_reset));
            if (i == 2) check(32'(core_reset));
            if (state == 2'd2) hold_n++;
            if (i > 2 && !core_reset && first_low == 0) first_low = i;
            rst_req = (i < 5) ? 3'b010 : 3'b000;
        end
        check(32'(hold_n));
        check(32'(first_low));
        check(32'(reset_cnt));

        // Downloads outside REQ_MASK: index 2 sets its flag, index 7 is ignored
        push_exp("nr_img_loaded", 3'b101);
        push_exp("nr_core_reset_hi", 0);
        push_exp("nr_state", 3);
        push_exp("oob_img_loaded", 3'b101);
        cr_snap = cr_hi_cnt;
        do_download(8'd2, 3);
        repeat (6) @(negedge clk_sys);
        check(32'(img_loaded));
        check(32'(cr_hi_cnt - cr_snap));
        check(32'(state));
        do_download(8'd7, 3);
        repeat (4) @(negedge clk_sys);
        check(32'(img_loaded));

`ifdef DL_HOLD_EN
        // Required-image download in S_RUN: flag clears and S_LOAD at the
        // sampled rising edge, core_reset follows one clock later.
        push_exp("hold_img_clr", 3'b100);
        push_exp("hold_state_load", 1);
        push_exp("hold_cr_lag", 0);
        push_exp("hold_cr_high", 1);
        ioctl_download = 1'b1;
        ioctl_index    = 8'd0;
        @(negedge clk_sys);
        check(32'(img_loaded));
        check(32'(state));
        check(32'(core_reset));
        @(negedge clk_sys);
        check(32'(core_reset));
        repeat (2) @(negedge clk_sys);
        ioctl_download = 1'b0;
        wait_state(2'd3, 60, "hold_rerun");
        push_exp("hold_img_back", 3'b101);
        check(32'(img_loaded));
`else
        // Required-image download in S_RUN leaves the core running
        push_exp("dl0_core_reset_hi", 0);
        push_exp("dl0_state", 3);
        push_exp("dl0_img_loaded", 3'b101);
        cr_snap = cr_hi_cnt;
        do_download(8'd0, 4);
        repeat (3) @(negedge clk_sys);
        check(32'(cr_hi_cnt - cr_snap));
        check(32'(state));
        check(32'(img_loaded));
`endif

        // Unload coincident with download end of index 0: clear wins
        push_exp("unl_img_loaded", 3'b100);
        push_exp("unl_state", 1);
        push_exp("unl_core_reset", 1);
        push_exp("unl_state_stays", 1);
        ioctl_download = 1'b1;
        ioctl_index    = 8'd0;
        repeat (2) @(negedge clk_sys);
        ioctl_download = 1'b0;
        unl_req        = 3'b001;
        @(negedge clk_sys);
        unl_req = 3'b000;
        @(negedge clk_sys);
        check(32'(img_loaded));
        check(32'(state));
        check(32'(core_reset));
        repeat (5) @(negedge clk_sys);
        check(32'(state));
        do_download(8'd0, 2);
        wait_state(2'd3, 60, "unl_rerun");

        // Lock loss for one clock: seen after SYNC flops, FSM one clock later
        push_exp("lock_loss_latency", 1);
        push_exp("lock_state_seq", 10'b11_00_01_10_11);
        push_exp("lock_core_reset_end", 0);
        push_exp("lock_reset_cnt", 1);
        pll_locked = 1'b0;
        @(negedge clk_sys);
        pll_locked = 1'b1;
        first_zero = 0;
        code       = 32'(state);
        last       = state;
        for (int n = 2; n <= 60; n++) begin
            @(negedge clk_sys);
            if (state != last) begin
                code = (code << 2) | 32'(state);
                last = state;
            end
            if (state == 2'd0 && first_zero == 0) first_zero = n;
        end
        check(32'(first_zero > 0 && first_zero <= SYNC + 1));
        check(code);
        check(32'(core_reset));
        check(32'(reset_cnt));

        // Saturation: total of 300 run-time resets
        push_exp("sat_timeouts_254", 0);
        push_exp("sat_reset_cnt_254", 254);
        push_exp("sat_timeouts_300", 0);
        push_exp("sat_reset_cnt_300", 255);
        timeouts = 0;
        for (int k = 2; k <= 300; k++) begin
            int w;
            rst_req = 3'b001;
            @(negedge clk_sys);
            rst_req = 3'b000;
            w = 0;
            while (state !== 2'd3 && w < 40) begin
                @(negedge clk_sys);
                w++;
            end
            if (state !== 2'd3) timeouts++;
            if (k == 254) begin
                check(32'(timeouts));
                check(32'(reset_cnt));
            end
        end
        check(32'(timeouts));
        check(32'(reset_cnt));

        // Reset asserted mid-download: its end after reset sets nothing
        push_exp("mid_rst_state", 0);
        push_exp("mid_rst_img", 0);
        push_exp("mid_rst_reset_cnt", 0);
        push_exp("mid_rst_discard", 0);
        push_exp("post_rst_dl", 3'b010);
        ioctl_download = 1'b1;
        ioctl_index    = 8'd1;
        repeat (2) @(negedge clk_sys);
        res_n = 1'b0;
        @(negedge clk_sys);
        check(32'(state));
        check(32'(img_loaded));
        check(32'(reset_cnt));
        res_n = 1'b1;
        repeat (3) @(negedge clk_sys);
        ioctl_download = 1'b0;
        repeat (3) @(negedge clk_sys);
        check(32'(img_loaded));
        do_download(8'd1, 2);
        repeat (2) @(negedge clk_sys);
        check(32'(img_loaded));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
